// File: rtl/clause_bin_sched.sv
// Sequencer for clause_array: loads one clause bin row by row, runs the implication loop, issues backtrack pulses.
// Optional stats ports via `define CLAUSE_SCHED_STATS_EN (stat_iter_o, stat_bcp_cnt_o).
module clause_bin_sched #(
   parameter int NUM_CLAUSES = 8,
   parameter int NUM_VARS    = 8,
   parameter int WIDTH_C_LEN = 4,
   parameter int WIDTH_ADDR  = 8,
   parameter int ARRAY_LAT   = 1,
   parameter int MAX_ITER    = 15,
   localparam int WIDTH_ITER = $clog2(MAX_ITER + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_i,
   input  logic [WIDTH_ADDR-1:0]    base_addr_i,
   input  logic                     bcp_i,
   input  logic                     bkt_i,
   input  logic [NUM_VARS*3-1:0]    host_value_i,
   output logic                     mem_rd_o,
   output logic [WIDTH_ADDR-1:0]    mem_addr_o,
   input  logic                     mem_valid_i,
   input  logic [NUM_VARS*2-1:0]    mem_clause_i,
   input  logic [WIDTH_C_LEN-1:0]   mem_len_i,
   output logic [NUM_CLAUSES-1:0]   wr_o,
   output logic [NUM_VARS*2-1:0]    clause_o,
   output logic [WIDTH_C_LEN-1:0]   clause_len_o,
   output logic [NUM_VARS*3-1:0]    arr_value_o,
   input  logic [NUM_VARS*3-1:0]    arr_value_i,
   input  logic                     arr_confl_i,
   output logic                     apply_impl_o,
   output logic                     apply_bkt_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     confl_o,
   output logic                     timeout_o,
   output logic [NUM_VARS*3-1:0]    result_o
`ifdef CLAUSE_SCHED_STATS_EN
   ,
   output logic [WIDTH_ITER-1:0]    stat_iter_o,
   output logic [15:0]              stat_bcp_cnt_o
`endif
);

   localparam int WIDTH_ROW  = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
   localparam int WIDTH_WAIT = (ARRAY_LAT > 1) ? $clog2(ARRAY_LAT) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_LD_REQ, S_LD_WAIT, S_LD_WR, S_BCP_DRV, S_BCP_WAIT, S_BCP_CHK, S_BKT, S_DONE
   } state_t;

   state_t                  r_state;
   logic [WIDTH_ADDR-1:0]   r_base;
   logic [WIDTH_ROW-1:0]    r_row;
   logic [WIDTH_ITER-1:0]   r_iter;
   logic [WIDTH_WAIT-1:0]   r_wait;
   logic                    r_mem_rd;
   logic [WIDTH_ADDR-1:0]   r_mem_addr;
   logic [NUM_CLAUSES-1:0]  r_wr;
   logic [NUM_VARS*2-1:0]   r_clause;
   logic [WIDTH_C_LEN-1:0]  r_len;
   logic [NUM_VARS*3-1:0]   r_arr_value;
   logic                    r_apply_bkt;
   logic                    r_done;
   logic                    r_confl;
   logic                    r_timeout;
   logic [NUM_VARS*3-1:0]   r_result;

   logic                    w_fix;
   logic                    w_apply;
   logic [WIDTH_ITER-1:0]   w_iter_nxt;

   // The apply pulse must coincide with the check cycle, so it cannot be registered.
   assign w_fix      = (arr_value_i == r_arr_value);
   assign w_apply    = (r_state == S_BCP_CHK) && !arr_confl_i && !w_fix;
   assign w_iter_nxt = r_iter + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_row       <= '0;
         r_iter      <= '0;
         r_wait      <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_wr        <= '0;
         r_clause    <= '0;
         r_len       <= '0;
         r_arr_value <= '0;
         r_apply_bkt <= 1'b0;
         r_done      <= 1'b0;
         r_confl     <= 1'b0;
         r_timeout   <= 1'b0;
         r_result    <= '0;
      end else begin
         r_mem_rd    <= 1'b0;
         r_wr        <= '0;
         r_apply_bkt <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (load_i) begin
                  r_base     <= base_addr_i;
                  r_row      <= '0;
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= base_addr_i;
                  r_confl    <= 1'b0;
                  r_timeout  <= 1'b0;
                  r_state    <= S_LD_REQ;
               end else if (bkt_i) begin
                  r_apply_bkt <= 1'b1;
                  r_confl     <= 1'b0;
                  r_timeout   <= 1'b0;
                  r_state     <= S_BKT;
               end else if (bcp_i) begin
                  r_confl   <= 1'b0;
                  r_timeout <= 1'b0;
                  r_state   <= S_BCP_DRV;
               end
            end
            S_LD_REQ: r_state <= S_LD_WAIT;
            S_LD_WAIT: begin
               if (mem_valid_i) begin
                  r_wr     <= NUM_CLAUSES'(1) << r_row;
                  r_clause <= mem_clause_i;
                  r_len    <= mem_len_i;
                  r_state  <= S_LD_WR;
               end
            end
            S_LD_WR: begin
               if (r_row == WIDTH_ROW'(NUM_CLAUSES - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_row      <= r_row + 1'b1;
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= r_base + WIDTH_ADDR'(r_row) + WIDTH_ADDR'(1);
                  r_state    <= S_LD_REQ;
               end
            end
            S_BCP_DRV: begin
               r_arr_value <= host_value_i;
               r_iter      <= '0;
               r_wait      <= '0;
               r_state     <= S_BCP_WAIT;
            end
            S_BCP_WAIT: begin
               if (r_wait == WIDTH_WAIT'(ARRAY_LAT - 1)) r_state <= S_BCP_CHK;
               else                                      r_wait  <= r_wait + 1'b1;
            end
            S_BCP_CHK: begin
               // Conflict takes precedence over a coincidental fixpoint.
               if (arr_confl_i) begin
                  r_confl  <= 1'b1;
                  r_result <= r_arr_value;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else if (w_fix) begin
                  r_result <= r_arr_value;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_arr_value <= arr_value_i;
                  r_iter      <= w_iter_nxt;
                  if (w_iter_nxt == WIDTH_ITER'(MAX_ITER)) begin
                     r_timeout <= 1'b1;
                     r_result  <= arr_value_i;
                     r_done    <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_wait  <= '0;
                     r_state <= S_BCP_WAIT;
                  end
               end
            end
            S_BKT: begin
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_rd_o     = r_mem_rd;
   assign mem_addr_o   = r_mem_addr;
   assign wr_o         = r_wr;
   assign clause_o     = r_clause;
   assign clause_len_o = r_len;
   assign arr_value_o  = r_arr_value;
   assign apply_impl_o = w_apply;
   assign apply_bkt_o  = r_apply_bkt;
   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = r_done;
   assign confl_o      = r_confl;
   assign timeout_o    = r_timeout;
   assign result_o     = r_result;

`ifdef CLAUSE_SCHED_STATS_EN
   logic                  w_bcp_end;
   logic [WIDTH_ITER-1:0] w_rounds;
   logic [WIDTH_ITER-1:0] r_stat_iter;
   logic [15:0]           r_stat_cnt;

   assign w_bcp_end = (r_state == S_BCP_CHK) &&
                      (arr_confl_i || w_fix || (w_iter_nxt == WIDTH_ITER'(MAX_ITER)));
   assign w_rounds  = (arr_confl_i || w_fix) ? r_iter : w_iter_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stat_iter <= '0;
         r_stat_cnt  <= '0;
      end else if (w_bcp_end) begin
         r_stat_iter <= w_rounds;
         if (r_stat_cnt != 16'hFFFF) r_stat_cnt <= r_stat_cnt + 16'd1;
      end
   end

   assign stat_iter_o    = r_stat_iter;
   assign stat_bcp_cnt_o = r_stat_cnt;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
